distance_averager: RTL and testbench
====================================

DISTANCE_AVERAGER -- requirements
Module: distance_averager

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, giving the bit width of the distance sample and the distance output.
REQ-002 The block SHALL have parameter LOG2_DEPTH, default 4, so the averaging window is 2**LOG2_DEPTH = 16 samples.
REQ-003 The block SHALL have parameter MAX_DIST, default 2000, the upper clamp matching the range of the distance-to-frequency-step table.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: when low, all state holds and inputs are ignored.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of the window.
REQ-008 The block SHALL have port sample_valid, input, 1 bit: raw sample present this cycle.
REQ-009 The block SHALL have port sample, input, WIDTH bits: raw unsigned distance sample.
REQ-010 The block SHALL have port distance, output, WIDTH bits: averaged, clamped distance for the FM DAC.
REQ-011 The block SHALL have port distance_valid, output, 1 bit: level; high while the window is full.
REQ-012 The block SHALL have port distance_update, output, 1 bit: one-cycle strobe when distance changes value source.

Function
REQ-013 A sample SHALL be accepted on a rising edge where enable=1, sample_valid=1 and flush=0.
REQ-014 An accepted sample SHALL be clamped to min(sample, MAX_DIST) before storage and summation.
REQ-015 Storage SHALL be a circular buffer of 2**LOG2_DEPTH entries addressed by wr_ptr, which wraps from 2**LOG2_DEPTH-1 to 0.
REQ-016 The running sum SHALL be WIDTH+LOG2_DEPTH bits wide and updated on acceptance as sum + new - buffer[wr_ptr], which can never overflow or underflow.
REQ-017 The FSM SHALL have two states, FILL and RUN.
REQ-018 In FILL, a fill counter SHALL increment per accepted sample; on the edge accepting sample number 2**LOG2_DEPTH, the state SHALL become RUN.
REQ-019 In RUN, the state SHALL remain RUN until flush or reset.
REQ-020 distance SHALL register sum >> LOG2_DEPTH (truncating) one clock after each acceptance in RUN, including the acceptance that entered RUN; latency is 1 cycle.
REQ-021 distance_update SHALL be high for exactly the cycle in which distance is newly loaded.
REQ-022 distance_valid SHALL rise together with the first distance load, then stay high in RUN.
REQ-023 In FILL, distance SHALL hold 0 and distance_valid SHALL be 0.
REQ-024 flush=1 with enable=1 SHALL, on that edge, zero the sum, fill counter, wr_ptr, distance, distance_valid and distance_update, set FILL, and drop any simultaneous sample.
REQ-025 Buffer contents need not be cleared on flush, because the sum and fill logic must never subtract entries written before the flush: in FILL the subtracted term SHALL be forced to 0.
REQ-026 With enable=0, flush and sample_valid SHALL be ignored, distance_update SHALL be 0, and all other state SHALL hold.
REQ-027 Back-to-back acceptances on every cycle SHALL be supported with no dropped samples.

Reset
REQ-028 While reset_n=0, the block SHALL hold distance=0, distance_valid=0, distance_update=0, sum=0, fill counter=0, wr_ptr=0 and state=FILL, independent of clk.
REQ-029 Reset asserted mid-window SHALL discard the partial window; operation SHALL resume in FILL after release.

Structure
REQ-030 WIDTH, MAX_DIST and the FSM state enum SHALL be declared in shared package fm_pkg, which the FM DAC and distance-to-frequency-step table also use.
REQ-031 The circular buffer SHALL be a single sub-module, dist_sample_buf, with a synchronous write port and a combinational read at wr_ptr; the remaining logic stays in distance_averager.

Verification
REQ-032 The bench SHALL check: reset, then 16 consecutive samples of 1000 -> distance_valid=0 through sample 15; the cycle after sample 16: distance=1000, distance_valid=1, distance_update=1.
REQ-033 The bench SHALL check: full window of 1000, then one sample of 1160 -> distance=1010 next cycle; 15 more samples of 1160 -> distance=1160.
REQ-034 The bench SHALL check: sample 8191 -> stored as 2000; a full window of 8191 -> distance=2000, never exceeding MAX_DIST.
REQ-035 The bench SHALL check: full window, then flush asserted together with sample_valid (sample 500) -> next cycle distance=0, distance_valid=0, FILL; 16 samples of 300 -> distance=300, with no 500 contribution.
REQ-036 The bench SHALL check: enable=0 for 10 cycles with sample_valid=1 -> distance, sum and pointers unchanged, distance_update=0.
REQ-037 The bench SHALL check: reset_n pulsed low after 8 samples -> outputs zero immediately; 16 samples of 700 after release -> distance=700.

Source files
------------

// File: rtl/fm_pkg.sv
// ---------------------------------------------------------------------------
// fm_pkg -- shared definitions for the FM distance path.
//   The distance averager, the FM DAC and the distance-to-frequency-step
//   table all import this package.
//   WIDTH       : bit width of a distance sample / averaged distance
//   MAX_DIST    : largest distance the frequency-step table covers
//   avg_state_t : averager FSM states (FILL while the window is filling,
//                 RUN once it holds a full window)
// ---------------------------------------------------------------------------
package fm_pkg;

  localparam int WIDTH    = 13;
  localparam int MAX_DIST = 2000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_t;

endpackage : fm_pkg

// File: rtl/dist_sample_buf.sv
// ---------------------------------------------------------------------------
// dist_sample_buf -- circular sample store for distance_averager.
//   Synchronous write port, combinational (asynchronous) read port.
//   Ports:
//     clk     : system clock, write on rising edge
//     wr_en   : write strobe
//     wr_addr : write address
//     wr_data : sample to store
//     rd_addr : read address
//     rd_data : stored sample at rd_addr, combinational
// ---------------------------------------------------------------------------
module dist_sample_buf #(
  parameter int WIDTH      = 13,
  parameter int LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [LOG2_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**LOG2_DEPTH];

  // NOTE: the array has no reset on purpose; a resettable memory cannot map
  // onto RAM/LUTRAM. Stale entries are harmless because the averager never
  // subtracts an entry it has not rewritten since the last flush or reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : dist_sample_buf

// File: rtl/distance_averager.sv
// ---------------------------------------------------------------------------
// distance_averager -- moving average of raw distance samples over a
// 2**LOG2_DEPTH-sample window, clamped to MAX_DIST, for the FM DAC.
//   Ports:
//     clk             : system clock, rising edge
//     reset_n         : asynchronous active-low reset
//     enable          : when low all state holds and inputs are ignored
//     flush           : synchronous clear of the window (qualified by enable)
//     sample_valid    : raw sample present this cycle
//     sample          : raw unsigned distance sample
//     distance        : averaged, clamped distance (0 until the window fills)
//     distance_valid  : high while a full window is held
//     distance_update : one-cycle strobe when distance is newly loaded
// ---------------------------------------------------------------------------
module distance_averager
  import fm_pkg::*;
#(
  parameter int WIDTH      = fm_pkg::WIDTH,
  parameter int LOG2_DEPTH = 4,
  parameter int MAX_DIST   = fm_pkg::MAX_DIST
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             flush,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] distance,
  output logic             distance_valid,
  output logic             distance_update
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;

  avg_state_t            state;
  logic [SUM_W-1:0]      sum;
  logic [LOG2_DEPTH-1:0] fill_cnt;
  logic [LOG2_DEPTH-1:0] wr_ptr;

  logic                  accept;
  logic [WIDTH-1:0]      sample_clamped;
  logic [WIDTH-1:0]      oldest;
  logic [WIDTH-1:0]      sub_term;
  logic [SUM_W-1:0]      sum_next;
  logic                  last_fill;
  logic                  load_dist;

  assign accept         = enable & sample_valid & ~flush;
  assign sample_clamped = (sample > WIDTH'(MAX_DIST)) ? WIDTH'(MAX_DIST) : sample;

  // While filling, the slot at wr_ptr may hold a sample from before the last
  // flush, so it must not leave the sum.
  assign sub_term  = (state == RUN) ? oldest : '0;
  // SUM_W bits hold DEPTH full-scale samples, so this never wraps.
  assign sum_next  = sum + SUM_W'(sample_clamped) - SUM_W'(sub_term);
  assign last_fill = (fill_cnt == LOG2_DEPTH'(DEPTH - 1));
  // The acceptance that completes the window loads distance as well.
  assign load_dist = accept & ((state == RUN) | last_fill);

  dist_sample_buf #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (sample_clamped),
    .rd_addr (wr_ptr),
    .rd_data (oldest)
  );

  // NOTE: every register below is assigned with <= so that each one samples
  // the pre-edge value of the others; blocking = here would create
  // order-dependent, simulation-vs-synthesis mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= FILL;
      sum             <= '0;
      fill_cnt        <= '0;
      wr_ptr          <= '0;
      distance        <= '0;
      distance_valid  <= 1'b0;
      distance_update <= 1'b0;
    end else begin
      distance_update <= 1'b0;
      if (enable) begin
        if (flush) begin
          state          <= FILL;
          sum            <= '0;
          fill_cnt       <= '0;
          wr_ptr         <= '0;
          distance       <= '0;
          distance_valid <= 1'b0;
        end else if (accept) begin
          sum    <= sum_next;
          wr_ptr <= wr_ptr + 1'b1;
          if (state == FILL) begin
            fill_cnt <= fill_cnt + 1'b1;
            if (last_fill) begin
              state <= RUN;
            end
          end
          if (load_dist) begin
            distance        <= sum_next[LOG2_DEPTH +: WIDTH];
            distance_valid  <= 1'b1;
            distance_update <= 1'b1;
          end
        end
      end
    end
  end

endmodule : distance_averager

// File: tb/tb_distance_averager.sv
// ---------------------------------------------------------------------------
// tb_distance_averager -- directed self-checking bench for distance_averager.
// Inputs change on the falling edge; outputs are checked on the following
// falling edge, i.e. half a cycle after the rising edge that acted on them.
// ---------------------------------------------------------------------------
module tb_distance_averager;
  import fm_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic             flush;
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] distance;
  logic             distance_valid;
  logic             distance_update;

  int total = 0;
  int bad   = 0;

  distance_averager #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (4),
    .MAX_DIST   (MAX_DIST)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .flush           (flush),
    .sample_valid    (sample_valid),
    .sample          (sample),
    .distance        (distance),
    .distance_valid  (distance_valid),
    .distance_update (distance_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, return at the next falling edge.
  task automatic drive(input logic en, input logic vld, input logic fl,
                       input int value);
    enable       = en;
    sample_valid = vld;
    flush        = fl;
    sample       = WIDTH'(value);
    @(negedge clk);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    flush        = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (2) @(negedge clk);

    // Reset state, with the clock running
    check("rst_distance", 32'(distance), 32'd0);
    check("rst_valid",    32'(distance_valid), 32'd0);
    check("rst_update",   32'(distance_update), 32'd0);
    check("rst_state",    32'(dut.state), 32'(FILL));
    reset_n = 1'b1;
    @(negedge clk);

    // First window: 16 x 1000
    for (int i = 1; i <= 15; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1000);
      check("fill_valid", 32'(distance_valid), 32'd0);
    end
    check("fill_distance_zero", 32'(distance), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1000);
    check("first_distance", 32'(distance), 32'd1000);
    check("first_valid",    32'(distance_valid), 32'd1);
    check("first_update",   32'(distance_update), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 0);
    check("idle_update",    32'(distance_update), 32'd0);
    check("idle_distance",  32'(distance), 32'd1000);

    // Sliding: (16000 - 1000 + 1160) / 16 = 1010
    drive(1'b1, 1'b1, 1'b0, 1160);
    check("slide_one", 32'(distance), 32'd1010);
    check("slide_one_update", 32'(distance_update), 32'd1);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 1160);
    check("slide_full", 32'(distance), 32'd1160);
    check("slide_sum",  32'(dut.sum), 32'd18560);
    // Three more so wr_ptr sits away from zero: 35 acceptances -> 3
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1160);
    check("ptr_before_hold", 32'(dut.wr_ptr), 32'd3);

    // enable=0 for 10 cycles with sample_valid and flush asserted
    drive(1'b0, 1'b1, 1'b1, 50);
    check("hold_update_first", 32'(distance_update), 32'd0);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b1, 50);
    check("hold_distance", 32'(distance), 32'd1160);
    check("hold_valid",    32'(distance_valid), 32'd1);
    check("hold_update",   32'(distance_update), 32'd0);
    check("hold_sum",      32'(dut.sum), 32'd18560);
    check("hold_ptr",      32'(dut.wr_ptr), 32'd3);
    check("hold_state",    32'(dut.state), 32'(RUN));

    // Clamp: flush, then 8191 stored as 2000
    drive(1'b1, 1'b0, 1'b1, 0);
    check("flush_valid", 32'(distance_valid), 32'd0);
    check("flush_ptr",   32'(dut.wr_ptr), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8191);
    check("clamp_stored", 32'(dut.u_buf.mem[0]), 32'd2000);
    check("clamp_sum",    32'(dut.sum), 32'd2000);
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 8191);
    check("clamp_distance", 32'(distance), 32'd2000);
    check("clamp_valid",    32'(distance_valid), 32'd1);

    // Flush together with a sample of 500: the sample is dropped
    drive(1'b1, 1'b1, 1'b1, 500);
    check("flush500_distance", 32'(distance), 32'd0);
    check("flush500_valid",    32'(distance_valid), 32'd0);
    check("flush500_update",   32'(distance_update), 32'd0);
    check("flush500_state",    32'(dut.state), 32'(FILL));
    check("flush500_sum",      32'(dut.sum), 32'd0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 300);
    check("refill_distance", 32'(distance), 32'd300);
    check("refill_sum",      32'(dut.sum), 32'd4800);

    // 8 samples of 100 into the 300 window: (4800 - 2400 + 800) / 16 = 200
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 100);
    check("pre_reset_distance", 32'(distance), 32'd200);

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    check("async_distance", 32'(distance), 32'd0);
    check("async_valid",    32'(distance_valid), 32'd0);
    check("async_update",   32'(distance_update), 32'd0);
    check("async_sum",      32'(dut.sum), 32'd0);
    check("async_ptr",      32'(dut.wr_ptr), 32'd0);
    check("async_state",    32'(dut.state), 32'(FILL));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b1, 1'b0, 700);
    check("post_reset_fill_valid", 32'(distance_valid), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 700);
    check("post_reset_distance", 32'(distance), 32'd700);
    check("post_reset_valid",    32'(distance_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_distance_averager
